// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and helpers for the systolic array sequencer
// Contents: ctrl_state_e FSM encoding, PE_LATENCY (pe output register depth),
// drain_cycles() giving the number of cycles for the last wavefront to leave the array.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        SWITCH,
        STREAM,
        DRAIN,
        DONE
    } ctrl_state_e;

    localparam int PE_LATENCY = 1;

    function automatic int drain_cycles(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// rtl/systolic_ctrl_if.sv - job request, buffer read and array control bundle
// Ports carried: start/num_vecs (job request), busy/done (status), wbuf_rd_*/ubuf_rd_*
// (buffer reads), accept_w/valid_row/switch_row/pe_enabled (array control), psum_vld
// (output capture). Optional: perf_busy_cycles/perf_jobs when SYSTOLIC_CTRL_PERF_EN is defined.
// master = job issuer / observer, slave = sequencer.
interface systolic_ctrl_if #(
    parameter int ROWS     = 2,
    parameter int COLS     = 2,
    parameter int MAX_VECS = 16,
    parameter int CNT_W    = $clog2(MAX_VECS + 1)
);

    logic                     start;
    logic [CNT_W-1:0]         num_vecs;
    logic                     busy;
    logic                     done;
    logic                     wbuf_rd_en;
    logic [$clog2(ROWS)-1:0]  wbuf_rd_addr;
    logic                     ubuf_rd_en;
    logic [CNT_W-1:0]         ubuf_rd_addr;
    logic [COLS-1:0]          accept_w;
    logic [ROWS-1:0]          valid_row;
    logic [ROWS-1:0]          switch_row;
    logic                     pe_enabled;
    logic                     psum_vld;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0]              perf_busy_cycles;
    logic [15:0]              perf_jobs;

    modport master (
        output start, num_vecs,
        input  busy, done, wbuf_rd_en, wbuf_rd_addr, ubuf_rd_en, ubuf_rd_addr,
        input  accept_w, valid_row, switch_row, pe_enabled, psum_vld,
        input  perf_busy_cycles, perf_jobs
    );

    modport slave (
        input  start, num_vecs,
        output busy, done, wbuf_rd_en, wbuf_rd_addr, ubuf_rd_en, ubuf_rd_addr,
        output accept_w, valid_row, switch_row, pe_enabled, psum_vld,
        output perf_busy_cycles, perf_jobs
    );
`else
    modport master (
        output start, num_vecs,
        input  busy, done, wbuf_rd_en, wbuf_rd_addr, ubuf_rd_en, ubuf_rd_addr,
        input  accept_w, valid_row, switch_row, pe_enabled, psum_vld
    );

    modport slave (
        input  start, num_vecs,
        output busy, done, wbuf_rd_en, wbuf_rd_addr, ubuf_rd_en, ubuf_rd_addr,
        output accept_w, valid_row, switch_row, pe_enabled, psum_vld
    );
`endif

endinterface

// File: rtl/systolic_ctrl_skew_shift.sv
// rtl/systolic_ctrl_skew_shift.sv - tapped delay line producing per-row control skew
// Ports: clk, rst (sync active-high), bit_in, taps[DEPTH-1:0] where taps[i] is bit_in
// delayed i cycles (taps[0] is bit_in itself).
module skew_shift #(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    output logic [DEPTH-1:0] taps
);

    assign taps[0] = bit_in;

    for (genvar i = 1; i < DEPTH; i++) begin : g_tap
        logic q;

        always_ff @(posedge clk) begin
            if (rst) begin
                q <= 1'b0;
            end else begin
                q <= taps[i-1];
            end
        end

        assign taps[i] = q;
    end

endmodule

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - weight-stationary systolic array job sequencer
// Ports: clk, rst (sync active-high), bus (systolic_ctrl_if.slave: start/num_vecs in;
// busy, done, buffer read strobes/addresses, accept_w, skewed valid_row/switch_row,
// pe_enabled, psum_vld out). Macro SYSTOLIC_CTRL_PERF_EN adds perf_busy_cycles/perf_jobs.
// Job: LOAD_W (ROWS) -> SWITCH (1) -> STREAM (vec_q) -> DRAIN (ROWS+COLS-1) -> DONE (1).
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int ROWS     = 2,
    parameter int COLS     = 2,
    parameter int MAX_VECS = 16,
    parameter int CNT_W    = $clog2(MAX_VECS + 1)
) (
    input  logic clk,
    input  logic rst,
    systolic_ctrl_if.slave bus
);

    localparam int AW        = $clog2(ROWS);
    localparam int CW        = (CNT_W > AW) ? CNT_W : AW;
    localparam int DRAIN_LEN = drain_cycles(ROWS, COLS);

    ctrl_state_e            state_q;
    ctrl_state_e            state_d;
    logic [CW-1:0]          cnt_q;
    logic [CNT_W-1:0]       vec_q;
    logic                   valid_in;
    logic                   switch_in;
    logic [ROWS-1:0]        valid_taps;
    logic [ROWS-1:0]        switch_taps;
    logic [PE_LATENCY-1:0]  psum_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Phase counter: restarts on every state change so each phase counts from 0.
    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE || state_d != state_q) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q <= '0;
        end else if (state_q == IDLE && bus.start) begin
            vec_q <= (bus.num_vecs > CNT_W'(MAX_VECS)) ? CNT_W'(MAX_VECS) : bus.num_vecs;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = LOAD_W;
            LOAD_W:  if (cnt_q == CW'(ROWS - 1)) state_d = SWITCH;
            SWITCH:  state_d = (vec_q != '0) ? STREAM : DRAIN;
            STREAM:  if (cnt_q == CW'(vec_q) - CW'(1)) state_d = DRAIN;
            DRAIN:   if (cnt_q == CW'(DRAIN_LEN - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy         = (state_q != IDLE);
        bus.done         = 1'b0;
        bus.wbuf_rd_en   = 1'b0;
        bus.wbuf_rd_addr = '0;
        bus.ubuf_rd_en   = 1'b0;
        bus.ubuf_rd_addr = '0;
        bus.accept_w     = '0;
        valid_in         = 1'b0;
        switch_in        = 1'b0;
        case (state_q)
            LOAD_W: begin
                // Bottom row first: weights ripple down from the top as accept_w shifts them.
                bus.wbuf_rd_en   = 1'b1;
                bus.wbuf_rd_addr = AW'(ROWS - 1) - cnt_q[AW-1:0];
                bus.accept_w     = '1;
            end
            SWITCH: switch_in = 1'b1;
            STREAM: begin
                bus.ubuf_rd_en   = 1'b1;
                bus.ubuf_rd_addr = cnt_q[CNT_W-1:0];
                valid_in         = 1'b1;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    skew_shift #(.DEPTH(ROWS)) u_valid_skew (
        .clk    (clk),
        .rst    (rst),
        .bit_in (valid_in),
        .taps   (valid_taps)
    );

    skew_shift #(.DEPTH(ROWS)) u_switch_skew (
        .clk    (clk),
        .rst    (rst),
        .bit_in (switch_in),
        .taps   (switch_taps)
    );

    // Bottom-row result appears PE_LATENCY cycles after its valid reaches that row.
    always_ff @(posedge clk) begin
        if (rst) begin
            psum_pipe <= '0;
        end else begin
            psum_pipe <= (psum_pipe << 1) | PE_LATENCY'(valid_taps[ROWS-1]);
        end
    end

    assign bus.valid_row  = valid_taps;
    assign bus.switch_row = switch_taps;
    assign bus.psum_vld   = psum_pipe[PE_LATENCY-1];
    assign bus.pe_enabled = 1'b1;

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] perf_busy_q;
    logic [15:0] perf_jobs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy_q <= '0;
            perf_jobs_q <= '0;
        end else begin
            if (bus.busy && perf_busy_q != '1) perf_busy_q <= perf_busy_q + 1'b1;
            if (bus.done && perf_jobs_q != '1) perf_jobs_q <= perf_jobs_q + 1'b1;
        end
    end

    assign bus.perf_busy_cycles = perf_busy_q;
    assign bus.perf_jobs        = perf_jobs_q;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - scoreboard bench for systolic_ctrl (ROWS=2, COLS=2, MAX_VECS=16)
module tb_systolic_ctrl;

    localparam int R  = 2;
    localparam int C  = 2;
    localparam int MV = 16;
    localparam int CW = $clog2(MV + 1);
    localparam int AW = $clog2(R);

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          wen;
        logic [AW-1:0] waddr;
        logic          uen;
        logic [CW-1:0] uaddr;
        logic [C-1:0]  acc;
        logic [R-1:0]  vrow;
        logic [R-1:0]  srow;
        logic          psum;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    systolic_ctrl_if #(.ROWS(R), .COLS(C), .MAX_VECS(MV)) bus_if ();

    systolic_ctrl #(.ROWS(R), .COLS(C), .MAX_VECS(MV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        model_busy = 1'b0;
    logic        model_done = 1'b0;
    int          start_cyc = 0;
    int          exp_lat = 0;
    int          done_cnt = 0;
    int          psum_cnt = 0;
    int          uread_cnt = 0;
    int unsigned m_perf_busy = 0;
    int unsigned m_perf_jobs = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected per-cycle outputs of one job, starting with the cycle right after start is taken.
    task automatic push_job(input int n_req);
        int   n;
        int   tot;
        exp_t e;
        n   = (n_req > MV) ? MV : n_req;
        tot = 2 * R + n + C + 1;
        for (int j = 0; j < tot; j++) begin
            e      = '0;
            e.busy = 1'b1;
            if (j < R) begin
                e.wen   = 1'b1;
                e.waddr = AW'(R - 1 - j);
                e.acc   = '1;
            end else if (j >= R + 1 && j < R + 1 + n) begin
                e.uen   = 1'b1;
                e.uaddr = CW'(j - R - 1);
            end
            e.done = (j == tot - 1);
            for (int i = 0; i < R; i++) begin
                e.srow[i] = (j - i == R);
                e.vrow[i] = (j - i >= R + 1) && (j - i < R + 1 + n);
            end
            e.psum = (j - R >= R + 1) && (j - R < R + 1 + n);
            exp_q.push_back(e);
        end
        exp_lat = tot;
    endtask

    task automatic tick();
        logic   s_rst;
        logic   s_start;
        int     s_nv;
        exp_t   e;
        @(posedge clk);
        s_rst   = rst;
        s_start = bus_if.start;
        s_nv    = int'(bus_if.num_vecs);
        #1;
        cyc++;
        if (s_rst) begin
            exp_q.delete();
            m_perf_busy = 0;
            m_perf_jobs = 0;
        end else begin
            if (model_busy && m_perf_busy != 32'hffff_ffff) m_perf_busy++;
            if (model_done && m_perf_jobs != 32'h0000_ffff) m_perf_jobs++;
            if (s_start && !model_busy) begin
                push_job(s_nv);
                start_cyc = cyc - 1;
            end
        end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = '0;

        check_eq("busy",         bus_if.busy,         e.busy);
        check_eq("done",         bus_if.done,         e.done);
        check_eq("wbuf_rd_en",   bus_if.wbuf_rd_en,   e.wen);
        check_eq("wbuf_rd_addr", bus_if.wbuf_rd_addr, e.waddr);
        check_eq("ubuf_rd_en",   bus_if.ubuf_rd_en,   e.uen);
        check_eq("ubuf_rd_addr", bus_if.ubuf_rd_addr, e.uaddr);
        check_eq("accept_w",     bus_if.accept_w,     e.acc);
        check_eq("valid_row",    bus_if.valid_row,    e.vrow);
        check_eq("switch_row",   bus_if.switch_row,   e.srow);
        check_eq("psum_vld",     bus_if.psum_vld,     e.psum);
        check_eq("pe_enabled",   bus_if.pe_enabled,   1);
`ifdef SYSTOLIC_CTRL_PERF_EN
        check_eq("perf_busy_cycles", bus_if.perf_busy_cycles, m_perf_busy);
        check_eq("perf_jobs",        {16'b0, bus_if.perf_jobs}, m_perf_jobs);
`endif
        model_busy = e.busy;
        model_done = e.done;
        if (bus_if.done) begin
            done_cnt++;
            check_eq("done_latency", cyc - start_cyc, exp_lat);
        end
        if (bus_if.psum_vld)   psum_cnt++;
        if (bus_if.ubuf_rd_en) uread_cnt++;
    endtask

    task automatic clear_counts();
        done_cnt  = 0;
        psum_cnt  = 0;
        uread_cnt = 0;
    endtask

    task automatic issue(input int n);
        bus_if.start    = 1'b1;
        bus_if.num_vecs = CW'(n);
        tick();
        bus_if.start    = 1'b0;
    endtask

    // Ticks until the expected trace is consumed; ends with the DONE cycle on the outputs.
    task automatic run_out(input int max_cyc);
        int k = 0;
        while (exp_q.size() > 0 && k < max_cyc) begin
            tick();
            k++;
        end
        check_eq("job_timeout", exp_q.size(), 0);
    endtask

    initial begin
        rst             = 1'b1;
        bus_if.start    = 1'b0;
        bus_if.num_vecs = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        clear_counts();
        issue(3);
        run_out(100);
        tick();
        check_eq("basic_done_cnt", done_cnt, 1);
        check_eq("basic_psum_cnt", psum_cnt, 3);
        check_eq("basic_reads",    uread_cnt, 3);

        clear_counts();
        issue(0);
        run_out(100);
        tick();
        check_eq("zero_done_cnt", done_cnt, 1);
        check_eq("zero_psum_cnt", psum_cnt, 0);
        check_eq("zero_reads",    uread_cnt, 0);

        clear_counts();
        issue(31);
        run_out(100);
        tick();
        check_eq("clamp_psum_cnt", psum_cnt, MV);
        check_eq("clamp_reads",    uread_cnt, MV);

        clear_counts();
        issue(3);
        tick();
        tick();
        tick();
        bus_if.start    = 1'b1;
        bus_if.num_vecs = CW'(2);
        tick();
        bus_if.start = 1'b0;
        run_out(100);
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check_eq("busy_start_done_cnt", done_cnt, 1);
        check_eq("busy_start_psum_cnt", psum_cnt, 3);

        clear_counts();
        issue(5);
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check_eq("reset_done_cnt", done_cnt, 0);

        clear_counts();
        issue(3);
        run_out(100);
        tick();
        issue(3);
        run_out(100);
        tick();
        check_eq("b2b_done_cnt", done_cnt, 2);
        check_eq("b2b_psum_cnt", psum_cnt, 6);
`ifdef SYSTOLIC_CTRL_PERF_EN
        check_eq("b2b_perf_jobs", {16'b0, bus_if.perf_jobs}, 2);
        check_eq("b2b_perf_busy", bus_if.perf_busy_cycles, 20);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
